// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state, constants and control bundle for the pipeline sequencing controller
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [4:0] XZR = 5'd31;
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } ctrl_t;
    localparam ctrl_t CTRL_RUN    = 8'b11111_000;
    localparam ctrl_t CTRL_RESET  = 8'b00000_111;
    // MEM/WB keeps loading so the stalled access drains as a bubble instead of a duplicate
    localparam ctrl_t CTRL_FREEZE = 8'b00001_001;
    localparam ctrl_t CTRL_FLUSH  = 8'b11111_110;
    localparam ctrl_t CTRL_STALL  = 8'b00111_010;
    function automatic logic stalled(ctrl_t c);
        return c != CTRL_RUN;
    endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage source that depends on a load still in EX
// Ports: mem_read/target describe the EX instruction; rn/rm/use_rn/use_rm the ID sources; hazard is the match.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] target,
    input  logic [4:0] rn,
    input  logic [4:0] rm,
    input  logic       use_rn,
    input  logic       use_rm,
    output logic       hazard
);
    assign hazard = mem_read && target != XZR && ((use_rn && rn == target) || (use_rm && rm == target));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: per-cycle load/hold/bubble control for the IF/ID, ID/EX, EX/MEM and MEM/WB registers
// Ports: hazard inputs from ID/EX/MEM, memory handshake (memAccess_MEM, mem_ack); register enables,
// flush/bubble controls, sticky mem_error and a saturating stall_cycles counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memRead_EX,
    input  logic [4:0]       targetReg_EX,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             useRn_ID,
    input  logic             useRm_ID,
    input  logic             branchTaken_EX,
    input  logic             memAccess_MEM,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    state_t state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic hazard, freeze, timeout;
    ctrl_t c;
    load_use_detect u_lud (
        .mem_read(memRead_EX),
        .target  (targetReg_EX),
        .rn      (Rn_ID),
        .rm      (Rm_ID),
        .use_rn  (useRn_ID),
        .use_rm  (useRm_ID),
        .hazard  (hazard)
    );
    // the freeze starts in the very cycle the unacknowledged access is seen, not one cycle later
    assign freeze  = (state == MEM_WAIT || memAccess_MEM) && !mem_ack;
    assign timeout = state == MEM_WAIT && !mem_ack && wcnt == WW'(MEM_TIMEOUT - 1);
    always_comb begin
        c = CTRL_RUN;
        if (reset) c = CTRL_RESET;
        else if (freeze) c = CTRL_FREEZE;
        else if (state == RUN && branchTaken_EX) c = CTRL_FLUSH;
        else if (state == RUN && hazard) c = CTRL_STALL;
    end
    always_comb begin
        state_n = state == RUN ? (memAccess_MEM && !mem_ack ? MEM_WAIT : RUN)
                               : (mem_ack || timeout ? RUN : MEM_WAIT);
        wcnt_n  = state == MEM_WAIT && state_n == MEM_WAIT ? wcnt + 1'b1 : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wcnt         <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_n;
            wcnt         <= wcnt_n;
            mem_error    <= mem_error | timeout;
            stall_cycles <= stall_cycles + CNT_W'(stalled(c) && !(&stall_cycles));
        end
    end
    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, mem_wb_bubble} = c;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the pipeline sequencing controller
module tb_pipeline_hazard_ctrl;
    localparam logic [7:0] RUNC = 8'b11111_000;
    localparam logic [7:0] RSTC = 8'b00000_111;
    localparam logic [7:0] FRZ  = 8'b00001_001;
    localparam logic [7:0] BR   = 8'b11111_110;
    localparam logic [7:0] LU   = 8'b00111_010;
    logic clk = 1'b0, reset = 1'b1;
    logic memRead_EX, useRn_ID, useRm_ID, branchTaken_EX, memAccess_MEM, mem_ack;
    logic [4:0] targetReg_EX, Rn_ID, Rm_ID;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, mem_wb_bubble, mem_error;
    logic [31:0] stall_cycles;
    logic [7:0] ctrl;
    logic [40:0] q[$];
    logic [40:0] x;
    logic [31:0] m_stall = 0;
    logic m_err = 1'b0;
    int total = 0, bad = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .memRead_EX(memRead_EX), .targetReg_EX(targetReg_EX),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .useRn_ID(useRn_ID), .useRm_ID(useRm_ID),
        .branchTaken_EX(branchTaken_EX), .memAccess_MEM(memAccess_MEM), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .mem_wb_bubble(mem_wb_bubble), .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, mem_wb_bubble};

    task automatic drive(input logic mr, input logic [4:0] t, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic br, input logic ma, input logic ack);
        memRead_EX = mr; targetReg_EX = t; Rn_ID = rn; Rm_ID = rm; useRn_ID = urn; useRm_ID = urm;
        branchTaken_EX = br; memAccess_MEM = ma; mem_ack = ack;
    endtask

    task automatic push(input logic [7:0] e);
        if (reset) begin m_stall = 0; m_err = 1'b0; end
        q.push_back({e, m_err, m_stall});
        if (!reset && e != RUNC) m_stall++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RSTC); end
                1, 2, 3: begin reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 1, 0); push(FRZ); end
                4, 5: begin reset = 1'b1; push(RSTC); end
                6: begin reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RUNC); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); push(RUNC); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL reset[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(1, 5, 5, 0, 1, 0, 0, 0, 0); push(LU); end
                1: begin drive(0, 5, 5, 0, 1, 0, 0, 0, 0); push(RUNC); end
                2: begin drive(1, 31, 31, 31, 1, 1, 0, 0, 0); push(RUNC); end
                3: begin drive(1, 9, 3, 9, 0, 1, 0, 0, 0); push(LU); end
                4: begin drive(1, 9, 9, 9, 0, 0, 0, 0, 0); push(RUNC); end
                default: begin drive(1, 9, 9, 4, 1, 1, 0, 0, 0); push(LU); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL load_use[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin drive(1, 7, 0, 7, 0, 1, 1, 0, 0); push(BR); end
                1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RUNC); end
                default: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); push(BR); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL branch[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [31:0] s0;
        s0 = m_stall;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2, 3: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); push(FRZ); end
                4: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); push(RUNC); end
                5: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RUNC); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); push(RUNC); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL mem_wait[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
        total++;
        if (stall_cycles - s0 !== 32'd4) begin
            bad++; $display("FAIL mem_wait_stalls got=%0d want=4", stall_cycles - s0);
        end
    endtask

    task automatic test_freeze_branch();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1: begin drive(1, 7, 7, 0, 1, 0, 1, 1, 0); push(FRZ); end
                2: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 1); push(RUNC); end
                default: begin drive(0, 0, 0, 0, 0, 0, 1, 0, 0); push(BR); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL freeze_branch[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 20; i++) begin
            if (i <= 16) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); push(FRZ); end
            else begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RUNC); end
            if (i == 16) m_err = 1'b1;
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL timeout[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_error_clear();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push(RSTC); end
                default: begin reset = 1'b0; push(RUNC); end
            endcase
            @(negedge clk); x = q.pop_front(); total++;
            if ({ctrl, mem_error, stall_cycles} !== x) begin
                bad++; $display("FAIL error_clear[%0d] got=%h want=%h", i, {ctrl, mem_error, stall_cycles}, x);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_freeze_branch();
        test_timeout();
        test_error_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
